sdf_stage16: RTL and testbench

SDF_STAGE16 -- requirements
Module: sdf_stage16

---
 rtl/sdf_stage16.sv | 117 +++++++++++
 tb/tb_sdf_stage16.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sdf_stage16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdf_stage16 : radix-2 single-path delay-feedback FFT stage, 16-deep line.   |
// | Overflow option: define SDF_SAT_EN to saturate instead of wrap.             |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module sdf_stage16 #(
  parameter int FRAC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [23:0] din_r,
  input  logic signed [23:0] din_i,
  input  logic [1:0]         state,
  input  logic signed [23:0] w_r,
  input  logic signed [23:0] w_i,
  output logic               out_valid,
  output logic signed [23:0] dout_r,
  output logic signed [23:0] dout_i
);

  localparam int         DEPTH   = 16;
  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BFLY = 2'd1;
  localparam logic [1:0] ST_TWID = 2'd2;

  // Every push shifts the whole line, so a plain shift register is the FIFO.
  logic [47:0] dl_q [DEPTH];
  logic        push_en;
  logic [47:0] push_val;

  logic        out_valid_q, out_valid_d;
  logic [23:0] dout_r_q, dout_r_d;
  logic [23:0] dout_i_q, dout_i_d;

  logic signed [23:0] old_r, old_i;
  logic signed [24:0] sum_r, sum_i, dif_r, dif_i;
  logic signed [48:0] prod_r, prod_i;

  function automatic logic [23:0] reduce24(input logic signed [48:0] v);
`ifdef SDF_SAT_EN
    if (v > 49'sd8388607)       return 24'h7FFFFF;
    else if (v < -49'sd8388608) return 24'h800000;
    else                        return v[23:0];
`else
    return v[23:0];
`endif
  endfunction

  assign old_r = dl_q[DEPTH-1][47:24];
  assign old_i = dl_q[DEPTH-1][23:0];

  assign sum_r = 25'(old_r) + 25'(din_r);
  assign sum_i = 25'(old_i) + 25'(din_i);
  assign dif_r = 25'(old_r) - 25'(din_r);
  assign dif_i = 25'(old_i) - 25'(din_i);

  // 49 bits hold the difference/sum of two full 48-bit products exactly.
  assign prod_r = (49'(old_r) * 49'(w_r) - 49'(old_i) * 49'(w_i)) >>> FRAC;
  assign prod_i = (49'(old_r) * 49'(w_i) + 49'(old_i) * 49'(w_r)) >>> FRAC;

  always_comb begin
    push_en     = 1'b0;
    push_val    = '0;
    out_valid_d = 1'b0;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    case (state)
      ST_FILL: begin
        if (in_valid) begin
          push_en  = 1'b1;
          push_val = {din_r, din_i};
        end
      end
      ST_BFLY: begin
        if (in_valid) begin
          push_en     = 1'b1;
          push_val    = {reduce24(49'(dif_r)), reduce24(49'(dif_i))};
          out_valid_d = 1'b1;
          dout_r_d    = reduce24(49'(sum_r));
          dout_i_d    = reduce24(49'(sum_i));
        end
      end
      ST_TWID: begin
        push_en     = 1'b1;
        out_valid_d = 1'b1;
        dout_r_d    = reduce24(prod_r);
        dout_i_d    = reduce24(prod_i);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
      if (push_en) begin
        dl_q[0] <= push_val;
        for (int i = 1; i < DEPTH; i++) dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;

endmodule
`default_nettype wire

// File: tb/tb_sdf_stage16.sv
`default_nettype none
// tb_sdf_stage16 : directed bench with a queue-based behavioural model of the SDF stage.
module tb_sdf_stage16;
  localparam int FRAC = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic [1:0]         state = 2'd3;
  logic signed [23:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
  logic               out_valid;
  logic signed [23:0] dout_r, dout_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdf_stage16 #(.FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .din_r(din_r), .din_i(din_i), .state(state),
    .w_r(w_r), .w_i(w_i),
    .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i)
  );

  // Reduction of an exact integer result to the 24-bit output format.
  function automatic longint fit(input longint v);
    logic signed [23:0] t;
`ifdef SDF_SAT_EN
    if (v > 64'sd8388607)  return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
`else
    t = v[23:0];
    return longint'(t);
`endif
  endfunction

  longint mq_r[$], mq_i[$];
  bit     exp_v;
  longint exp_r, exp_i;

  always @(posedge clk or negedge reset) begin
    longint xr, xi;
    if (!reset) begin
      mq_r = {}; mq_i = {};
      for (int k = 0; k < 16; k++) begin mq_r.push_back(0); mq_i.push_back(0); end
      exp_v = 0; exp_r = 0; exp_i = 0;
    end else begin
      exp_v = 0;
      if (state == 2'd0 && in_valid) begin
        void'(mq_r.pop_front()); void'(mq_i.pop_front());
        mq_r.push_back(din_r); mq_i.push_back(din_i);
      end else if (state == 2'd1 && in_valid) begin
        xr = mq_r.pop_front(); xi = mq_i.pop_front();
        exp_v = 1;
        exp_r = fit(xr + din_r);
        exp_i = fit(xi + din_i);
        mq_r.push_back(fit(xr - din_r)); mq_i.push_back(fit(xi - din_i));
      end else if (state == 2'd2) begin
        xr = mq_r.pop_front(); xi = mq_i.pop_front();
        exp_v = 1;
        exp_r = fit((xr * w_r - xi * w_i) >>> FRAC);
        exp_i = fit((xr * w_i + xi * w_r) >>> FRAC);
        mq_r.push_back(0); mq_i.push_back(0);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_valid", longint'(out_valid), longint'(exp_v));
    chk("model_dout_r", longint'(dout_r), exp_r);
    chk("model_dout_i", longint'(dout_i), exp_i);
  end

  task automatic drv(input logic [1:0] st, input logic iv,
                     input longint dr, input longint di, input longint wr, input longint wi);
    state = st; in_valid = iv;
    din_r = 24'(dr); din_i = 24'(di); w_r = 24'(wr); w_i = 24'(wi);
    @(negedge clk);
  endtask

  task automatic frame();
    for (int k = 0; k < 16; k++) drv(2'd0, 1'b1, k, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      drv(2'd1, 1'b1, 100, 0, 0, 0);
      chk("bfly_valid", longint'(out_valid), 1);
      chk("bfly_r", longint'(dout_r), 100 + k);
      chk("bfly_i", longint'(dout_i), 0);
    end
  endtask

  function automatic longint rnd(input int unsigned span);
    return longint'($urandom_range(0, 2 * span)) - longint'(span);
  endfunction

  initial begin
    @(negedge clk);
    repeat (5) begin
      state = 2'($urandom); in_valid = 1'($urandom);
      din_r = 24'($urandom); din_i = 24'($urandom); w_r = 24'($urandom); w_i = 24'($urandom);
      @(negedge clk);
      chk("reset_valid", longint'(out_valid), 0);
      chk("reset_dout_r", longint'(dout_r), 0);
      chk("reset_dout_i", longint'(dout_i), 0);
    end
    reset = 1'b1;

    frame();
    drv(2'd3, 1'b1, 55, 7, 0, 0);
    chk("hold_valid", longint'(out_valid), 0);
    chk("hold_r", longint'(dout_r), 115);
    for (int k = 0; k < 16; k++) begin
      if (k == 8) drv(2'd2, 1'b0, 0, 0, 0, -256);
      else        drv(2'd2, 1'b0, 0, 0, 256, 0);
      if (k == 0) begin
        chk("unity_r", longint'(dout_r), -100);
        chk("unity_i", longint'(dout_i), 0);
      end
      if (k == 8) begin
        chk("negj_r", longint'(dout_r), 0);
        chk("negj_i", longint'(dout_i), 92);
      end
    end

    // Random complex frames with gaps; the second uses full-scale values.
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 20; k++)
        drv(2'd0, 1'($urandom_range(0, 3) != 0),
            f ? rnd(8388607) : rnd(3000), f ? rnd(8388607) : rnd(3000), 0, 0);
      for (int k = 0; k < 20; k++)
        drv(2'($urandom_range(0, 4) == 0 ? 3 : 1), 1'($urandom_range(0, 3) != 0),
            f ? rnd(8388607) : rnd(3000), f ? rnd(8388607) : rnd(3000), 0, 0);
      for (int k = 0; k < 16; k++)
        drv(2'd2, 1'($urandom), 0, 0,
            f ? rnd(8388607) : rnd(300), f ? rnd(8388607) : rnd(300));
    end

    // Mid-frame reset on the 5th butterfly cycle.
    for (int k = 0; k < 16; k++) drv(2'd0, 1'b1, k, 0, 0, 0);
    for (int k = 0; k < 4; k++) drv(2'd1, 1'b1, 100, 0, 0, 0);
    state = 2'd1; in_valid = 1'b1; din_r = 24'sd100; din_i = '0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", longint'(out_valid), 0);
    chk("midrst_r", longint'(dout_r), 0);
    chk("midrst_i", longint'(dout_i), 0);
    @(negedge clk);
    reset = 1'b1;
    frame();

    for (int k = 0; k < 16; k++) drv(2'd0, 1'b1, 24'h7FFFFF, 0, 0, 0);
    drv(2'd1, 1'b1, 24'h7FFFFF, 0, 0, 0);
`ifdef SDF_SAT_EN
    chk("ovf_sum_r", longint'(dout_r), 8388607);
`else
    chk("ovf_sum_r", longint'(dout_r), -2);
`endif
    for (int k = 0; k < 15; k++) drv(2'd1, 1'b1, 24'h7FFFFF, 0, 0, 0);
    for (int k = 0; k < 16; k++) drv(2'd2, 1'b0, 0, 0, 256, 0);
    drv(2'd3, 1'b0, 0, 0, 0, 0);
    drv(2'd3, 1'b0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
